// File: rtl/crypt_round_engine_pkg.sv
// Shared types, mode constants and rotate helpers for the crypt round engine.
// Optional feature macro: CRYPT_SALT_COUNTER_EN (see crypt_round_engine.sv).
package crypt_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Widest vector the rotate helpers handle; callers cast to/from their own width.
  localparam int unsigned MAX_W = 256;

  // Rotate the low w bits of x left by amt (mod w); bits at and above w are cleared.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned amt,
                                            input int unsigned w);
    int unsigned a;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] xm;
    a    = amt % w;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    xm   = x & mask;
    // With a == 0 the right shift by w clears xm, so the identity falls out.
    return ((xm << a) | (xm >> (w - a))) & mask;
  endfunction

  // Rotate the low w bits of x right by amt (mod w).
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int unsigned amt,
                                            input int unsigned w);
    return rotl(x, (w - (amt % w)) % w, w);
  endfunction

endpackage

// File: rtl/crypt_round_engine_if.sv
// Request/response handshake bundle between the packet layer and the round engine.
interface crypt_round_engine_if #(
  parameter int unsigned ENC_W = 78
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [ENC_W-1:0] in_data;
  logic [ENC_W-1:0] in_key;
  logic             out_valid;
  logic             out_ready;
  logic [ENC_W-1:0] out_data;
  logic             out_err;

  modport master (
    output in_valid, in_mode, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/crypt_round_engine_round.sv
// One combinational encrypt/decrypt round; the engine reuses it every RUN cycle.
module crypt_round
  import crypt_pkg::*;
#(
  parameter int unsigned ENC_W = 78,
  parameter int unsigned ROT   = 7
) (
  input  logic [ENC_W-1:0] s,
  input  logic [ENC_W-1:0] rk,
  input  logic             mode,
  output logic [ENC_W-1:0] s_next
);

  // Encrypt mixes then rotates left; decrypt undoes it by rotating right then mixing.
  always_comb begin
    s_next = '0;
    if (mode == MODE_ENC) begin
      s_next = ENC_W'(rotl(MAX_W'(s ^ rk), ROT, ENC_W));
    end else begin
      s_next = ENC_W'(rotr(MAX_W'(s), ROT, ENC_W)) ^ rk;
    end
  end

endmodule

// File: rtl/crypt_round_engine.sv
// Iterative parametrised encrypt/decrypt engine with valid/ready on both sides.
// Macro CRYPT_SALT_COUNTER_EN: salt comes from a free-wrapping counter instead of
// constant 0, and the decrypt salt-integrity error is disabled.
module crypt_round_engine
  import crypt_pkg::*;
#(
  parameter int unsigned DATA_W = 60,
  parameter int unsigned SALT_W = 18,
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned ROT    = 7
) (
  input logic           Clk,
  input logic           Rst,
  crypt_round_engine_if.slave bus
);

  localparam int unsigned ENC_W = DATA_W + SALT_W;
  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);
  localparam int unsigned DEC_RK_START = (ROUNDS - 1) % ENC_W;

  stateT            state;
  logic [CNT_W-1:0] roundCnt;
  logic             modeReg;
  logic [ENC_W-1:0] sReg;
  logic [ENC_W-1:0] rkReg;
  logic [ENC_W-1:0] rkNext;
  logic [ENC_W-1:0] sNext;
  logic [SALT_W-1:0] saltVal;
  logic             inReadyReg;
  logic             outValidReg;
  logic [ENC_W-1:0] outDataReg;
  logic             outErrReg;

`ifdef CRYPT_SALT_COUNTER_EN
  logic [SALT_W-1:0] saltCnt;

  // Salt counter advances once per accepted encrypt and wraps naturally.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      saltCnt <= '0;
    end else if (state == IDLE && bus.in_valid && bus.in_mode == MODE_ENC) begin
      saltCnt <= saltCnt + 1'b1;
    end
  end

  assign saltVal = saltCnt;
`else
  assign saltVal = '0;
`endif

  crypt_round #(
    .ENC_W(ENC_W),
    .ROT  (ROT)
  ) u_round (
    .s     (sReg),
    .rk    (rkReg),
    .mode  (modeReg),
    .s_next(sNext)
  );

  // Round key for the next round: rk(r+1) going up for encrypt, rk(r-1) going down for decrypt.
  always_comb begin
    rkNext = rkReg;
    if (modeReg == MODE_ENC) begin
      rkNext = ENC_W'(rotl(MAX_W'(rkReg), 1, ENC_W));
    end else begin
      rkNext = ENC_W'(rotr(MAX_W'(rkReg), 1, ENC_W));
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      roundCnt    <= '0;
      modeReg     <= MODE_ENC;
      sReg        <= '0;
      rkReg       <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
      outDataReg  <= '0;
      outErrReg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            modeReg    <= bus.in_mode;
            roundCnt   <= '0;
            inReadyReg <= 1'b0;
            state      <= RUN;
            if (bus.in_mode == MODE_ENC) begin
              sReg  <= {saltVal, bus.in_data[DATA_W-1:0]};
              rkReg <= bus.in_key;
            end else begin
              sReg  <= bus.in_data;
              // Decrypt starts from the last round key and walks back to rk(0).
              rkReg <= ENC_W'(rotl(MAX_W'(bus.in_key), DEC_RK_START, ENC_W));
            end
          end
        end
        RUN: begin
          if (roundCnt == CNT_W'(ROUNDS)) begin
            state       <= DONE;
            outValidReg <= 1'b1;
            outDataReg  <= sReg;
`ifdef CRYPT_SALT_COUNTER_EN
            outErrReg   <= 1'b0;
`else
            outErrReg   <= (modeReg == MODE_DEC) && (sReg[ENC_W-1:DATA_W] != '0);
`endif
          end else begin
            sReg     <= sNext;
            rkReg    <= rkNext;
            roundCnt <= roundCnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReadyReg;
  assign bus.out_valid = outValidReg;
  assign bus.out_data  = outDataReg;
  assign bus.out_err   = outErrReg;

endmodule

// File: tb/tb_crypt_round_engine.sv
// Directed self-checking bench for crypt_round_engine at default parameters.
module tb_crypt_round_engine;
  import crypt_pkg::*;

  localparam int unsigned ENC_W = 78;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  crypt_round_engine_if #(.ENC_W(ENC_W)) busIf ();

  crypt_round_engine #(
    .DATA_W(60),
    .SALT_W(18),
    .ROUNDS(4),
    .ROT   (7)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(busIf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ENC_W-1:0] obs,
                       input logic [ENC_W-1:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns #1 after the accept edge.
  task automatic sendReq(input logic mode, input logic [ENC_W-1:0] data,
                         input logic [ENC_W-1:0] key);
    @(negedge clk);
    check("in_ready_before_accept", ENC_W'(busIf.in_ready), ENC_W'(1));
    busIf.in_valid = 1'b1;
    busIf.in_mode  = mode;
    busIf.in_data  = data;
    busIf.in_key   = key;
    @(posedge clk);
    #1;
    busIf.in_valid = 1'b0;
    busIf.in_mode  = ~mode;
    busIf.in_data  = '1;
    busIf.in_key   = '1;
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic waitDone(output int edges);
    edges = 0;
    while (!busIf.out_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic takeResult(input string tag);
    @(negedge clk);
    busIf.out_ready = 1'b1;
    @(posedge clk);
    #1;
    busIf.out_ready = 1'b0;
    check({tag, "_valid_drop"}, ENC_W'(busIf.out_valid), ENC_W'(0));
    check({tag, "_ready_back"}, ENC_W'(busIf.in_ready), ENC_W'(1));
  endtask

  task automatic runOp(input string tag, input logic mode, input logic [ENC_W-1:0] data,
                       input logic [ENC_W-1:0] key, input logic [ENC_W-1:0] expData,
                       input logic expErr);
    int lat;
    sendReq(mode, data, key);
    waitDone(lat);
    check({tag, "_latency"}, ENC_W'(lat), ENC_W'(5));
    @(negedge clk);
    check({tag, "_data"}, busIf.out_data, expData);
    check({tag, "_err"}, ENC_W'(busIf.out_err), ENC_W'(expErr));
    takeResult(tag);
  endtask

  initial begin
    logic [ENC_W-1:0] held;
    logic             sawValid;
    int               lat;

    rst             = 1'b1;
    busIf.in_valid  = 1'b0;
    busIf.in_mode   = MODE_ENC;
    busIf.in_data   = '0;
    busIf.in_key    = '0;
    busIf.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", ENC_W'(busIf.in_ready), ENC_W'(1));
    check("reset_out_valid", ENC_W'(busIf.out_valid), ENC_W'(0));
    check("reset_out_data", busIf.out_data, '0);
    check("reset_out_err", ENC_W'(busIf.out_err), ENC_W'(0));

`ifdef CRYPT_SALT_COUNTER_EN
    // Salt 0 then salt 1; salt bit 60 rotated left by 28 lands at bit 10.
    runOp("salt_first", MODE_ENC, 78'h0, 78'h0, 78'h0, 1'b0);
    runOp("salt_second", MODE_ENC, 78'h0, 78'h0, 78'h400, 1'b0);
`else
    // Payload 1 rotated 4 x 7 = 28 bits.
    runOp("enc_one", MODE_ENC, 78'h1, 78'h0, 78'h1000_0000, 1'b0);
    // Upper bits of in_data are not part of an encrypt.
    runOp("enc_upper_ignored", MODE_ENC, {18'h3FFFF, 60'h1}, 78'h0, 78'h1000_0000, 1'b0);
    runOp("dec_one", MODE_DEC, 78'h1000_0000, 78'h0, 78'h1, 1'b0);
    runOp("dec_bad_salt", MODE_DEC, 78'h400, 78'h0, 78'h1 << 60, 1'b1);
    runOp("enc_key_ones", MODE_ENC, 78'h0, '1, 78'h0, 1'b0);
    runOp("dec_key_ones", MODE_DEC, 78'h0, '1, 78'h0, 1'b0);
    // Key bit 0 walks up one bit per round: bits 28, 22, 16, 10.
    runOp("enc_key_one", MODE_ENC, 78'h0, 78'h1, 78'h1041_0400, 1'b0);
    runOp("dec_key_one", MODE_DEC, 78'h1041_0400, 78'h1, 78'h0, 1'b0);

    // Backpressure: result must hold for 10 stalled cycles.
    sendReq(MODE_ENC, 78'h1, 78'h0);
    waitDone(lat);
    check("bp_latency", ENC_W'(lat), ENC_W'(5));
    @(negedge clk);
    held     = busIf.out_data;
    sawValid = 1'b1;
    check("bp_data", held, 78'h1000_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busIf.out_data !== held || busIf.in_ready !== 1'b0 || busIf.out_valid !== 1'b1) begin
        sawValid = 1'b0;
      end
    end
    check("bp_stable", ENC_W'(sawValid), ENC_W'(1));
    takeResult("bp");

    // Reset asserted during the second RUN cycle.
    sendReq(MODE_ENC, 78'h1, 78'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", ENC_W'(busIf.out_valid), ENC_W'(0));
    check("abort_in_ready", ENC_W'(busIf.in_ready), ENC_W'(1));
    check("abort_out_data", busIf.out_data, '0);
    @(negedge clk);
    rst      = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sawValid = sawValid | busIf.out_valid;
    end
    check("abort_no_valid", ENC_W'(sawValid), ENC_W'(0));
    runOp("after_abort", MODE_DEC, 78'h1000_0000, 78'h0, 78'h1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
